// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        VALID = 2'b10,
        ERR   = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } fetch_err_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC adder: sequential step or PC-relative signed offset, with word-alignment check.
module pc_next_calc
    import fetch_pkg::*;
(
    input  logic               [31:0] instr_pc,
    input  logic signed        [31:0] imm,
    input  logic                      seq_sel,
    output logic               [31:0] nxt,
    output logic                      misaligned
);

    // Modulo-2^32 addition; wrap past the top of the address space is intended.
    assign nxt        = seq_sel ? (instr_pc + INSTR_BYTES) : (instr_pc + $unsigned(imm));
    assign misaligned = |nxt[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem req/ack and decode valid/ready handshakes.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    fetch_state_t     state_q, state_d;
    fetch_err_t       err_code_q, err_code_d;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [31:0]      instr_pc_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             req_q;
    logic [31:0]      nxt;
    logic             misaligned;
    logic             fetch_done;
    logic             accept;

    assign fetch_done = (state_q == FETCH) && imem_ack;
    assign accept     = (state_q == VALID) && instr_ready;

    pc_next_calc u_next (
        .instr_pc   (instr_pc_q),
        .imm        (branch_imm),
        .seq_sel    (!branch_taken),
        .nxt        (nxt),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE: if (!halt) state_d = FETCH;
            FETCH: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    state_d = VALID;
                end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                    state_d    = ERR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    if (misaligned) begin
                        state_d    = ERR;
                        err_code_d = ERR_MISALIGN;
                    end else begin
                        state_d = halt ? IDLE : FETCH;
                    end
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            err_code_q <= ERR_NONE;
            req_q      <= 1'b0;
            pc_q       <= RESET_VECTOR;
            wait_cnt   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            req_q      <= (state_d == FETCH);
            if (fetch_done) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc_q;
                wait_cnt   <= '0;
            end else if (state_q == FETCH) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            // pc_q only ever advances to an aligned target, so ERR retains the last good PC.
            if (accept && !misaligned) pc_q <= nxt;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == VALID);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign err         = (state_q == ERR);
    assign err_code    = err_code_q;

endmodule
